// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD update stage: default widths, fixed-point
// constants for the default format and the iteration state encoding.
package spgd_pkg;

    localparam int FP_WIDTH_DEF      = 64;
    localparam int INT_WIDTH_DEF     = 16;
    localparam int SETTLE_CYCLES_DEF = 16;
    localparam int CNT_WIDTH_DEF     = 16;

    // 1.0 in the default Q16.48 format
    localparam logic signed [FP_WIDTH_DEF-1:0] FX_ONE  = 64'sh0001_0000_0000_0000;
    localparam logic signed [FP_WIDTH_DEF-1:0] SAT_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [FP_WIDTH_DEF-1:0] SAT_MIN = 64'sh8000_0000_0000_0000;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_APPLY_POS  = 4'd1,
        ST_SETTLE_POS = 4'd2,
        ST_MEAS_POS   = 4'd3,
        ST_APPLY_NEG  = 4'd4,
        ST_SETTLE_NEG = 4'd5,
        ST_MEAS_NEG   = 4'd6,
        ST_CALC1      = 4'd7,
        ST_CALC2      = 4'd8,
        ST_WRITE      = 4'd9
    } spgd_state_e;

endpackage

// File: rtl/spgd_update_mul.sv
// Signed fixed-point multiply: full-width product, then the INT/FRAC window
// is sliced out by truncation (no rounding).
module fx_mul_trunc
    import spgd_pkg::*;
#(
    parameter int FP_WIDTH  = FP_WIDTH_DEF,
    parameter int INT_WIDTH = INT_WIDTH_DEF
) (
    input  logic [FP_WIDTH-1:0] a,
    input  logic [FP_WIDTH-1:0] b,
    output logic [FP_WIDTH-1:0] p
);

    logic signed [2*FP_WIDTH-1:0] a_ext_s;
    logic signed [2*FP_WIDTH-1:0] b_ext_s;
    logic signed [2*FP_WIDTH-1:0] prod_s;
    logic                         unused_bits_s;

    assign a_ext_s = {{FP_WIDTH{a[FP_WIDTH-1]}}, a};
    assign b_ext_s = {{FP_WIDTH{b[FP_WIDTH-1]}}, b};
    assign prod_s  = a_ext_s * b_ext_s;
    assign p       = prod_s[2*FP_WIDTH-1-INT_WIDTH : FP_WIDTH-INT_WIDTH];

    // Overflowed integer bits and sub-LSB fraction bits are dropped on purpose
    assign unused_bits_s = ^{prod_s[2*FP_WIDTH-1 -: INT_WIDTH],
                             prod_s[FP_WIDTH-INT_WIDTH-1:0]};

endmodule

// File: rtl/spgd_update.sv
// One SPGD iteration per start pulse: drive u+p, measure J+, drive u-p,
// measure J-, then step u by GAIN*(J+ - J-)*p on both channels.
module spgd_update
    import spgd_pkg::*;
#(
    parameter int FP_WIDTH      = FP_WIDTH_DEF,
    parameter int INT_WIDTH     = INT_WIDTH_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [FP_WIDTH-1:0] PERT_A,
    input  logic [FP_WIDTH-1:0] PERT_B,
    input  logic [FP_WIDTH-1:0] GAIN,
    input  logic [FP_WIDTH-1:0] metric_in,
    input  logic                metric_valid,
    output logic                metric_req,
    output logic [FP_WIDTH-1:0] U_A,
    output logic [FP_WIDTH-1:0] U_B,
    output logic                busy,
    output logic                done
);

    localparam logic [FP_WIDTH-1:0]  POS_MAX       = {1'b0, {(FP_WIDTH-1){1'b1}}};
    localparam logic [FP_WIDTH-1:0]  NEG_MIN       = {1'b1, {(FP_WIDTH-1){1'b0}}};
    localparam logic [FP_WIDTH-1:0]  FP_ZERO       = {FP_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO      = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD   = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic                 SINGLE_SETTLE = (SETTLE_CYCLES == 1);

    // Add or subtract one bit wider than the operands, then clamp to the signed range
    function automatic logic [FP_WIDTH-1:0] sat_add(input logic [FP_WIDTH-1:0] a,
                                                    input logic [FP_WIDTH-1:0] b,
                                                    input logic                sub);
        logic [FP_WIDTH:0] a_ext;
        logic [FP_WIDTH:0] b_ext;
        logic [FP_WIDTH:0] sum;
        a_ext = {a[FP_WIDTH-1], a};
        b_ext = {b[FP_WIDTH-1], b};
        if (sub) begin
            sum = a_ext - b_ext;
        end else begin
            sum = a_ext + b_ext;
        end
        if (sum[FP_WIDTH] == sum[FP_WIDTH-1]) begin
            return sum[FP_WIDTH-1:0];
        end else if (sum[FP_WIDTH]) begin
            return NEG_MIN;
        end else begin
            return POS_MAX;
        end
    endfunction

    spgd_state_e          state_r;
    spgd_state_e          state_nxt_s;
    logic                 req_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [FP_WIDTH-1:0]  u_a_r;
    logic [FP_WIDTH-1:0]  u_b_r;
    logic [FP_WIDTH-1:0]  pa_r;
    logic [FP_WIDTH-1:0]  pb_r;
    logic [FP_WIDTH-1:0]  jp_r;
    logic [FP_WIDTH-1:0]  jm_r;
    logic [FP_WIDTH-1:0]  g_r;
    logic [FP_WIDTH-1:0]  sa_r;
    logic [FP_WIDTH-1:0]  sb_r;
    logic [FP_WIDTH-1:0]  drv_a_r;
    logic [FP_WIDTH-1:0]  drv_b_r;
    logic                 req_r;
    logic                 busy_r;
    logic                 done_r;

    logic [FP_WIDTH-1:0]  pos_a_s;
    logic [FP_WIDTH-1:0]  pos_b_s;
    logic [FP_WIDTH-1:0]  neg_a_s;
    logic [FP_WIDTH-1:0]  neg_b_s;
    logic [FP_WIDTH-1:0]  new_a_s;
    logic [FP_WIDTH-1:0]  new_b_s;
    logic [FP_WIDTH-1:0]  diff_s;
    logic [FP_WIDTH-1:0]  g_s;
    logic [FP_WIDTH-1:0]  s_a_s;
    logic [FP_WIDTH-1:0]  s_b_s;

    assign pos_a_s = sat_add(u_a_r, pa_r, 1'b0);
    assign pos_b_s = sat_add(u_b_r, pb_r, 1'b0);
    assign neg_a_s = sat_add(u_a_r, pa_r, 1'b1);
    assign neg_b_s = sat_add(u_b_r, pb_r, 1'b1);
    assign new_a_s = sat_add(u_a_r, sa_r, 1'b0);
    assign new_b_s = sat_add(u_b_r, sb_r, 1'b0);
    assign diff_s  = sat_add(jp_r, jm_r, 1'b1);

    fx_mul_trunc #(.FP_WIDTH(FP_WIDTH), .INT_WIDTH(INT_WIDTH)) u_mul_gain (
        .a (GAIN),
        .b (diff_s),
        .p (g_s)
    );

    fx_mul_trunc #(.FP_WIDTH(FP_WIDTH), .INT_WIDTH(INT_WIDTH)) u_mul_step_a (
        .a (g_r),
        .b (pa_r),
        .p (s_a_s)
    );

    fx_mul_trunc #(.FP_WIDTH(FP_WIDTH), .INT_WIDTH(INT_WIDTH)) u_mul_step_b (
        .a (g_r),
        .b (pb_r),
        .p (s_b_s)
    );

    // Next-state decode; metric_req is predicted one cycle early so it can be registered
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_APPLY_POS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_APPLY_POS: begin
                state_nxt_s = ST_SETTLE_POS;
                req_nxt_s   = SINGLE_SETTLE;
            end
            ST_SETTLE_POS: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_MEAS_POS;
                end else begin
                    state_nxt_s = ST_SETTLE_POS;
                end
                req_nxt_s = (cnt_r == CNT_ONE);
            end
            ST_MEAS_POS: begin
                if (metric_valid) begin
                    state_nxt_s = ST_APPLY_NEG;
                end else begin
                    state_nxt_s = ST_MEAS_POS;
                end
            end
            ST_APPLY_NEG: begin
                state_nxt_s = ST_SETTLE_NEG;
                req_nxt_s   = SINGLE_SETTLE;
            end
            ST_SETTLE_NEG: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_MEAS_NEG;
                end else begin
                    state_nxt_s = ST_SETTLE_NEG;
                end
                req_nxt_s = (cnt_r == CNT_ONE);
            end
            ST_MEAS_NEG: begin
                if (metric_valid) begin
                    state_nxt_s = ST_CALC1;
                end else begin
                    state_nxt_s = ST_MEAS_NEG;
                end
            end
            ST_CALC1: state_nxt_s = ST_CALC2;
            ST_CALC2: state_nxt_s = ST_WRITE;
            ST_WRITE: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            req_r   <= req_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_r == ST_WRITE);
        end
    end

    // Datapath: perturbation latch, actuator drive, metric capture and update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= CNT_ZERO;
            u_a_r   <= FP_ZERO;
            u_b_r   <= FP_ZERO;
            pa_r    <= FP_ZERO;
            pb_r    <= FP_ZERO;
            jp_r    <= FP_ZERO;
            jm_r    <= FP_ZERO;
            g_r     <= FP_ZERO;
            sa_r    <= FP_ZERO;
            sb_r    <= FP_ZERO;
            drv_a_r <= FP_ZERO;
            drv_b_r <= FP_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    drv_a_r <= u_a_r;
                    drv_b_r <= u_b_r;
                    if (start) begin
                        pa_r <= PERT_A;
                        pb_r <= PERT_B;
                    end
                end
                ST_APPLY_POS: begin
                    drv_a_r <= pos_a_s;
                    drv_b_r <= pos_b_s;
                    cnt_r   <= SETTLE_LOAD;
                end
                ST_APPLY_NEG: begin
                    drv_a_r <= neg_a_s;
                    drv_b_r <= neg_b_s;
                    cnt_r   <= SETTLE_LOAD;
                end
                ST_SETTLE_POS, ST_SETTLE_NEG: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_MEAS_POS: begin
                    if (metric_valid) begin
                        jp_r <= metric_in;
                    end
                end
                ST_MEAS_NEG: begin
                    if (metric_valid) begin
                        jm_r <= metric_in;
                    end
                end
                ST_CALC1: g_r <= g_s;
                ST_CALC2: begin
                    sa_r <= s_a_s;
                    sb_r <= s_b_s;
                end
                ST_WRITE: begin
                    u_a_r   <= new_a_s;
                    u_b_r   <= new_b_s;
                    drv_a_r <= new_a_s;
                    drv_b_r <= new_b_s;
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign metric_req = req_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign U_A        = drv_a_r;
    assign U_B        = drv_b_r;

endmodule

// File: tb/tb_spgd_update.sv
// Randomised self-checking bench for spgd_update against a plain-arithmetic
// model of the SPGD iteration (wide integers, clamp, shift).
module tb_spgd_update;
    import spgd_pkg::*;

    localparam int SETTLE = 4;
    typedef logic signed [63:0] fx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] PERT_A = 64'h0;
    logic [63:0] PERT_B = 64'h0;
    logic [63:0] GAIN = 64'h0;
    logic [63:0] metric_in = 64'h0;
    logic        metric_valid = 1'b0;
    logic        metric_req;
    logic [63:0] U_A;
    logic [63:0] U_B;
    logic        busy;
    logic        done;

    int  tests_run = 0;
    int  tests_failed = 0;
    fx_t m_ua = 64'sh0;
    fx_t m_ub = 64'sh0;

    always #5 clk = ~clk;

    spgd_update #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .PERT_A       (PERT_A),
        .PERT_B       (PERT_B),
        .GAIN         (GAIN),
        .metric_in    (metric_in),
        .metric_valid (metric_valid),
        .metric_req   (metric_req),
        .U_A          (U_A),
        .U_B          (U_B),
        .busy         (busy),
        .done         (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic fx_t m_clamp(input logic signed [127:0] x);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = {64'h0, SAT_MAX};
        lo = {64'hFFFF_FFFF_FFFF_FFFF, SAT_MIN};
        if (x > hi) return SAT_MAX;
        else if (x < lo) return SAT_MIN;
        else return x[63:0];
    endfunction

    function automatic fx_t m_add(input fx_t a, input fx_t b, input bit sub);
        logic signed [127:0] xa;
        logic signed [127:0] xb;
        xa = {{64{a[63]}}, a};
        xb = {{64{b[63]}}, b};
        return m_clamp(sub ? xa - xb : xa + xb);
    endfunction

    // real-valued product a*b / 2^48, keeping the low 64 bits
    function automatic fx_t m_mul(input fx_t a, input fx_t b);
        logic signed [127:0] xa;
        logic signed [127:0] xb;
        logic signed [127:0] p;
        xa = {{64{a[63]}}, a};
        xb = {{64{b[63]}}, b};
        p  = (xa * xb) >>> 48;
        return p[63:0];
    endfunction

    task automatic model_iter(input fx_t pa, input fx_t pb, input fx_t gain, input fx_t jp, input fx_t jm,
                              output fx_t pos_a, output fx_t pos_b, output fx_t neg_a, output fx_t neg_b);
        fx_t g;
        pos_a = m_add(m_ua, pa, 1'b0);
        pos_b = m_add(m_ub, pb, 1'b0);
        neg_a = m_add(m_ua, pa, 1'b1);
        neg_b = m_add(m_ub, pb, 1'b1);
        g     = m_mul(gain, m_add(jp, jm, 1'b1));
        m_ua  = m_add(m_ua, m_mul(g, pa), 1'b0);
        m_ub  = m_add(m_ub, m_mul(g, pb), 1'b0);
    endtask

    function automatic fx_t rand_fx(input int ibits);
        fx_t r;
        r = {$urandom(), $urandom()};
        return r >>> (16 - ibits);
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        start = 1'b0;
        metric_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        m_ua = 64'sh0;
        m_ub = 64'sh0;
    endtask

    // Run one iteration as the sensor side; cycle 0 is the start cycle
    task automatic run_iter(input fx_t pa, input fx_t pb, input fx_t gain, input fx_t jp, input fx_t jm,
                            input int dly, input int spur_cyc, input bit spur_req, input int restart_cyc,
                            output fx_t pos_a, output fx_t pos_b, output fx_t neg_a, output fx_t neg_b,
                            output int req1, output int req2, output int done_cyc, output bit busy_bad);
        int cyc;
        int nreq;
        int wait_cnt;
        pos_a = 64'sh0; pos_b = 64'sh0; neg_a = 64'sh0; neg_b = 64'sh0;
        req1 = -1; req2 = -1; done_cyc = -1; busy_bad = 1'b0;
        PERT_A = pa; PERT_B = pb; GAIN = gain; start = 1'b1;
        tick();
        start = 1'b0;
        PERT_A = {$urandom(), $urandom()};
        PERT_B = {$urandom(), $urandom()};
        cyc = 1; nreq = 0; wait_cnt = 0;
        while (cyc < 1000) begin
            metric_valid = 1'b0;
            start = 1'b0;
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    metric_valid = 1'b1;
                    metric_in = (nreq == 1) ? jp : jm;
                end
            end
            if (metric_req) begin
                nreq++;
                if (nreq == 1) begin
                    req1 = cyc; pos_a = U_A; pos_b = U_B;
                end else begin
                    req2 = cyc; neg_a = U_A; neg_b = U_B;
                end
                wait_cnt = dly;
                if (spur_req) begin
                    metric_valid = 1'b1;
                    metric_in = 64'h0BAD_0BAD_0BAD_0BAD;
                end
            end
            if (cyc == spur_cyc) begin
                metric_valid = 1'b1;
                metric_in = 64'h7123_4567_89AB_CDEF;
            end
            if (cyc == restart_cyc) begin
                start = 1'b1;
                PERT_A = ~pa;
                PERT_B = ~pb;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
            tick();
            cyc++;
        end
        metric_valid = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (U_A !== 64'h0 || U_B !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_u: got U_A=%h U_B=%h expected 0", U_A, U_B);
        end
        tests_run++;
        if ({busy, done, metric_req} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got busy/done/req=%b expected 000", {busy, done, metric_req});
        end
    endtask

    task automatic test_basic();
        fx_t pa, pb, gain, jp, jm, pa_p, pb_p, na_p, nb_p, ma, mb, mc, md;
        int r1, r2, dc;
        bit bb;
        pa = 64'sh0000_8000_0000_0000; pb = 64'shFFFF_C000_0000_0000;
        gain = 64'sh0000_4000_0000_0000; jp = 64'sh0003_0000_0000_0000; jm = FX_ONE;
        model_iter(pa, pb, gain, jp, jm, ma, mb, mc, md);
        run_iter(pa, pb, gain, jp, jm, 1, -1, 1'b0, -1, pa_p, pb_p, na_p, nb_p, r1, r2, dc, bb);
        tests_run++;
        if (pa_p !== 64'sh0000_8000_0000_0000 || pb_p !== 64'shFFFF_C000_0000_0000) begin
            tests_failed++;
            $display("FAIL basic_pos_drive: got %h %h expected 0000800000000000 ffffc00000000000", pa_p, pb_p);
        end
        tests_run++;
        if (na_p !== 64'shFFFF_8000_0000_0000 || nb_p !== 64'sh0000_4000_0000_0000) begin
            tests_failed++;
            $display("FAIL basic_neg_drive: got %h %h expected ffff800000000000 0000400000000000", na_p, nb_p);
        end
        tests_run++;
        if (U_A !== 64'sh0000_4000_0000_0000 || U_B !== 64'shFFFF_E000_0000_0000) begin
            tests_failed++;
            $display("FAIL basic_update: got %h %h expected 0000400000000000 ffffe00000000000", U_A, U_B);
        end
        tests_run++;
        if (r1 != 5 || r2 != 11 || dc != 2 * SETTLE + 8) begin
            tests_failed++;
            $display("FAIL timing_cycles: got req %0d,%0d done %0d expected 5,11,16", r1, r2, dc);
        end
        tests_run++;
        if (bb || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timing_busy: got gap=%0d busy_at_done=%b expected 0 0", bb, busy);
        end
        tick();
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_pulse: got done=%b after one cycle expected 0", done);
        end
    endtask

    task automatic test_handshake();
        fx_t pa, pb, gain, jp, jm, pa_p, pb_p, na_p, nb_p, ma, mb, mc, md;
        int r1, r2, dc;
        bit bb;
        apply_reset();
        pa = 64'sh0000_8000_0000_0000; pb = 64'shFFFF_C000_0000_0000;
        gain = 64'sh0000_4000_0000_0000; jp = 64'sh0003_0000_0000_0000; jm = FX_ONE;
        model_iter(pa, pb, gain, jp, jm, ma, mb, mc, md);
        run_iter(pa, pb, gain, jp, jm, 50, 3, 1'b1, -1, pa_p, pb_p, na_p, nb_p, r1, r2, dc, bb);
        tests_run++;
        if (U_A !== 64'sh0000_4000_0000_0000 || U_B !== 64'shFFFF_E000_0000_0000) begin
            tests_failed++;
            $display("FAIL handshake_update: got %h %h expected 0000400000000000 ffffe00000000000", U_A, U_B);
        end
        tests_run++;
        if (r1 != 5 || dc != 2 * SETTLE + 8 + 2 * 49 || bb) begin
            tests_failed++;
            $display("FAIL handshake_wait: got req1 %0d done %0d gap %0d expected 5 114 0", r1, dc, bb);
        end
    endtask

    task automatic test_ignored_start();
        fx_t pa, pb, gain, jp, jm, pa_p, pb_p, na_p, nb_p, ma, mb, mc, md;
        int r1, r2, dc;
        bit bb;
        pa = rand_fx(1); pb = rand_fx(1); gain = rand_fx(2); jp = rand_fx(4); jm = rand_fx(4);
        model_iter(pa, pb, gain, jp, jm, ma, mb, mc, md);
        run_iter(pa, pb, gain, jp, jm, 1, -1, 1'b0, 9, pa_p, pb_p, na_p, nb_p, r1, r2, dc, bb);
        tests_run++;
        if (U_A !== m_ua || U_B !== m_ub || dc != 2 * SETTLE + 8) begin
            tests_failed++;
            $display("FAIL ignored_start: got %h %h done %0d expected %h %h done 16", U_A, U_B, dc, m_ua, m_ub);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_start_queue: got busy=%b after done expected 0", busy);
        end
    endtask

    task automatic test_random();
        fx_t pa, pb, gain, jp, jm, pa_p, pb_p, na_p, nb_p, ma, mb, mc, md;
        int r1, r2, dc, dly;
        bit bb;
        for (int it = 0; it < 6; it++) begin
            pa = rand_fx(1); pb = rand_fx(1); gain = rand_fx(2); jp = rand_fx(4); jm = rand_fx(4);
            dly = int'($urandom_range(5, 1));
            model_iter(pa, pb, gain, jp, jm, ma, mb, mc, md);
            run_iter(pa, pb, gain, jp, jm, dly, -1, 1'b0, -1, pa_p, pb_p, na_p, nb_p, r1, r2, dc, bb);
            tests_run++;
            if (pa_p !== ma || pb_p !== mb || na_p !== mc || nb_p !== md) begin
                tests_failed++;
                $display("FAIL random_drive[%0d]: got %h %h %h %h expected %h %h %h %h",
                         it, pa_p, pb_p, na_p, nb_p, ma, mb, mc, md);
            end
            tests_run++;
            if (U_A !== m_ua || U_B !== m_ub || dc != 2 * SETTLE + 8 + 2 * (dly - 1)) begin
                tests_failed++;
                $display("FAIL random_update[%0d]: got %h %h done %0d expected %h %h done %0d",
                         it, U_A, U_B, dc, m_ua, m_ub, 2 * SETTLE + 8 + 2 * (dly - 1));
            end
        end
    endtask

    task automatic test_saturation();
        fx_t pa_p, pb_p, na_p, nb_p, ma, mb, mc, md;
        int r1, r2, dc;
        bit bb;
        apply_reset();
        model_iter(FX_ONE, 64'sh0, 64'sh7FFF_FFFF_FFFF_0000, FX_ONE, 64'sh0, ma, mb, mc, md);
        run_iter(FX_ONE, 64'sh0, 64'sh7FFF_FFFF_FFFF_0000, FX_ONE, 64'sh0, 1, -1, 1'b0, -1,
                 pa_p, pb_p, na_p, nb_p, r1, r2, dc, bb);
        tests_run++;
        if (U_A !== 64'h7FFF_FFFF_FFFF_0000 || U_B !== 64'h0) begin
            tests_failed++;
            $display("FAIL sat_setup: got %h %h expected 7fffffffffff0000 0", U_A, U_B);
        end
        model_iter(64'sh0000_8000_0000_0000, 64'sh0, FX_ONE, FX_ONE, 64'sh0, ma, mb, mc, md);
        run_iter(64'sh0000_8000_0000_0000, 64'sh0, FX_ONE, FX_ONE, 64'sh0, 1, -1, 1'b0, -1,
                 pa_p, pb_p, na_p, nb_p, r1, r2, dc, bb);
        tests_run++;
        if (pa_p !== 64'h7FFF_FFFF_FFFF_FFFF || na_p !== mc) begin
            tests_failed++;
            $display("FAIL sat_drive: got pos %h neg %h expected 7fffffffffffffff %h", pa_p, na_p, mc);
        end
        tests_run++;
        if (U_A !== 64'h7FFF_FFFF_FFFF_FFFF || U_A !== m_ua) begin
            tests_failed++;
            $display("FAIL sat_update: got %h expected 7fffffffffffffff", U_A);
        end
    endtask

    task automatic test_reset_mid();
        fx_t pa_p, pb_p, na_p, nb_p, ma, mb, mc, md, pa, pb, gain, jp, jm;
        int r1, r2, dc, nreq, cyc;
        bit bb, give;
        for (int it = 0; it < 2; it++) begin
            pa = rand_fx(1); pb = rand_fx(1); gain = rand_fx(2); jp = rand_fx(4); jm = rand_fx(4);
            model_iter(pa, pb, gain, jp, jm, ma, mb, mc, md);
            run_iter(pa, pb, gain, jp, jm, 1, -1, 1'b0, -1, pa_p, pb_p, na_p, nb_p, r1, r2, dc, bb);
            tests_run++;
            if (U_A !== m_ua || U_B !== m_ub) begin
                tests_failed++;
                $display("FAIL pre_reset_iter[%0d]: got %h %h expected %h %h", it, U_A, U_B, m_ua, m_ub);
            end
        end
        PERT_A = rand_fx(1); PERT_B = rand_fx(1); start = 1'b1;
        tick();
        start = 1'b0; nreq = 0; cyc = 0; give = 1'b0;
        while (nreq < 2 && cyc < 200) begin
            metric_valid = give;
            metric_in = rand_fx(4);
            give = 1'b0;
            if (metric_req) begin
                nreq++;
                give = 1'b1;
            end
            tick();
            cyc++;
        end
        metric_valid = 1'b0;
        tests_run++;
        if (nreq != 2) begin
            tests_failed++;
            $display("FAIL mid_reach_meas_neg: got %0d requests expected 2", nreq);
        end
        repeat (2) tick();
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (U_A !== 64'h0 || U_B !== 64'h0 || busy !== 1'b0 || done !== 1'b0 || metric_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %h %h busy=%b done=%b req=%b expected zeros",
                     U_A, U_B, busy, done, metric_req);
        end
        tick();
        rst = 1'b1;
        m_ua = 64'sh0;
        m_ub = 64'sh0;
        tick();
        pa = rand_fx(1); pb = rand_fx(1); gain = rand_fx(2); jp = rand_fx(4); jm = rand_fx(4);
        model_iter(pa, pb, gain, jp, jm, ma, mb, mc, md);
        run_iter(pa, pb, gain, jp, jm, 1, -1, 1'b0, -1, pa_p, pb_p, na_p, nb_p, r1, r2, dc, bb);
        tests_run++;
        if (U_A !== m_ua || U_B !== m_ub || pa_p !== pa || dc != 2 * SETTLE + 8) begin
            tests_failed++;
            $display("FAIL post_reset_iter: got %h %h pos %h done %0d expected %h %h pos %h done 16",
                     U_A, U_B, pa_p, dc, m_ua, m_ub, pa);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_handshake();
        test_ignored_start();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
